// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with a shared prescaler and period counter,
// per-channel duty compare and polarity, edge/center-aligned modes and
// double-buffered configuration committed only at period boundaries.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   enable       - run control; 0 freezes prescaler, counter and outputs
//   prescale     - counter advances once every prescale+1 clk cycles
//   period       - period value P
//   duty         - channel i duty at [i*(BITS+1) +: BITS+1]
//   center_mode  - 0 = edge-aligned, 1 = center-aligned
//   polarity     - per-channel output inversion
//   load         - captures all config inputs into the shadow set
//   pwm_out      - registered PWM outputs
//   period_tick  - one-cycle pulse after each period boundary
//   load_ack     - one-cycle pulse after the shadow set becomes active
module pwm_multi_channel #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned BITS       = 8,
    parameter int unsigned PRESC_BITS = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [PRESC_BITS-1:0]          prescale,
    input  logic [BITS-1:0]                period,
    input  logic [CHANNELS*(BITS+1)-1:0]   duty,
    input  logic                           center_mode,
    input  logic [CHANNELS-1:0]            polarity,
    input  logic                           load,
    output logic [CHANNELS-1:0]            pwm_out,
    output logic                           period_tick,
    output logic                           load_ack
);

    localparam int unsigned DW = BITS + 1;

    // Shadow (written by load) and active (used by the counter) config sets
    logic [PRESC_BITS-1:0]    presc_sh,  presc_act;
    logic [BITS-1:0]          period_sh, period_act;
    logic [CHANNELS*DW-1:0]   duty_sh,   duty_act;
    logic                     center_sh, center_act;
    logic [CHANNELS-1:0]      pol_sh,    pol_act;

    logic                     pending;
    logic [PRESC_BITS-1:0]    presc_cnt;
    logic [BITS-1:0]          cnt;
    // In center mode, down is the direction of the next step, so it is
    // already set while cnt sits at P and still set when cnt reaches 1.
    logic                     down;

    logic                     tick;
    logic                     boundary;
    logic                     commit;
    logic [BITS-1:0]          cnt_nxt;
    logic                     down_nxt;
    logic [CHANNELS-1:0]      pwm_nxt;

    // Tick, boundary, commit and next counter state
    always_comb begin
        tick     = enable && (presc_cnt == presc_act);
        boundary = 1'b0;
        cnt_nxt  = cnt;
        down_nxt = down;
        pwm_nxt  = '0;

        if (period_act == '0) begin
            boundary = tick;
            cnt_nxt  = '0;
            down_nxt = 1'b0;
        end else if (!center_act) begin
            boundary = tick && (cnt == period_act);
            cnt_nxt  = (cnt == period_act) ? '0 : cnt + BITS'(1);
            down_nxt = 1'b0;
        end else if (down) begin
            boundary = tick && (cnt == BITS'(1));
            cnt_nxt  = cnt - BITS'(1);
            down_nxt = (cnt != BITS'(1));
        end else begin
            cnt_nxt  = cnt + BITS'(1);
            down_nxt = (cnt == period_act - BITS'(1));
        end

        // A disabled block has no boundary to wait for, so commit at once
        commit = pending && (boundary || !enable);

        for (int i = 0; i < int'(CHANNELS); i++) begin
            pwm_nxt[i] = ({1'b0, cnt} < duty_act[i*DW +: DW]) ^ pol_act[i];
        end
    end

    // Config registers, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_sh    <= '0;
            period_sh   <= '0;
            duty_sh     <= '0;
            center_sh   <= 1'b0;
            pol_sh      <= '0;
            presc_act   <= '0;
            period_act  <= '0;
            duty_act    <= '0;
            center_act  <= 1'b0;
            pol_act     <= '0;
            pending     <= 1'b0;
            presc_cnt   <= '0;
            cnt         <= '0;
            down        <= 1'b0;
            pwm_out     <= '0;
            period_tick <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            if (load) begin
                presc_sh  <= prescale;
                period_sh <= period;
                duty_sh   <= duty;
                center_sh <= center_mode;
                pol_sh    <= polarity;
            end

            // A load on the commit edge re-arms pending for the next boundary
            pending <= load || (pending && !commit);

            if (commit) begin
                presc_act  <= presc_sh;
                period_act <= period_sh;
                duty_act   <= duty_sh;
                center_act <= center_sh;
                pol_act    <= pol_sh;
                presc_cnt  <= '0;
                cnt        <= '0;
                down       <= 1'b0;
            end else if (enable) begin
                presc_cnt <= tick ? '0 : presc_cnt + PRESC_BITS'(1);
                if (tick) begin
                    cnt  <= cnt_nxt;
                    down <= down_nxt;
                end
            end

            if (enable) begin
                pwm_out <= pwm_nxt;
            end
            period_tick <= boundary;
            load_ack    <= commit;
        end
    end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
Multi-channel PWM generator, the parametrised successor to the single-channel PWM block. It has a shared prescaler and a shared period counter, with a per-channel duty compare and per-channel output polarity. It supports edge-aligned and center-aligned modes. Configuration is double-buffered: shadow registers are loaded on request and committed only at a period boundary, so outputs never glitch. It sits between the register interface and motor/LED driver pins.

Parameters:
CHANNELS, 4, number of PWM outputs
BITS, 8, period counter width
PRESC_BITS, 8, prescaler width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run control; 0 freezes prescaler, counter and outputs
prescale  in  PRESC_BITS  counter advances once every prescale+1 clk cycles
period  in  BITS  period value P
duty  in  CHANNELS*(BITS+1)  channel i duty at [i*(BITS+1) +: BITS+1]
center_mode  in  1  0 = edge-aligned, 1 = center-aligned
polarity  in  CHANNELS  1 = invert channel output
load  in  1  single-cycle pulse; captures prescale/period/duty/center_mode/polarity into shadow registers
pwm_out  out  CHANNELS  registered PWM outputs
period_tick  out  1  one-cycle pulse at each period boundary
load_ack  out  1  one-cycle pulse when the shadow set becomes active

Behaviour:
- Reset: all shadow and active registers = 0, prescaler = 0, counter = 0, direction = up, pending = 0. pwm_out, period_tick and load_ack = 0 on the edge where reset is sampled high. Reset mid-period abandons the period and discards any pending load.
- load: on each clk edge with load=1, all config inputs are captured into shadow registers and pending is set to 1. A second load before commit overwrites the shadow; only one load_ack results.
- Prescaler: when enable=1, presc_cnt counts 0..prescale_act, then wraps. tick = enable & (presc_cnt == prescale_act). prescale_act=0 gives a tick every cycle.
- Edge mode: on each tick the counter runs 0,1..P,0. Period = P+1 ticks. Boundary = tick & (cnt == P).
- Center mode: on each tick the counter runs 0,1..P,P-1..1,0 and repeats; direction flips at P and at 0. Period = 2P ticks. Boundary = tick & down & (cnt == 1).
- P = 0 in either mode: cnt stays at 0 and every tick is a boundary.
- Commit: at a boundary edge with pending=1, all active registers take the shadow values. pending clears, cnt goes to 0 and direction goes to up.
- Commit while enable=0: a pending load commits on the next clk edge, without waiting for a boundary.
- Load coincident with commit: a load sampled on the same edge as a commit goes into the shadow, sets pending again and waits for the next boundary.
- period_tick: registered; high for one clk cycle after each boundary edge. It never pulses while enable=0.
- load_ack: registered; high for one clk cycle after each commit edge.
- Output: on every clk edge, pwm_out[i] is registered from (cnt < duty_act[i]) XOR polarity_act[i], giving one clk of latency from cnt.
  - duty = 0 gives constant inactive (0% duty).
  - duty > P gives constant active (100% duty) in both modes.
  - duty is BITS+1 wide so that 100% is expressible at P = 2^BITS-1.
- Comparison is unsigned. There is no arithmetic overflow: the counter never exceeds P.
- enable=0: presc_cnt and cnt hold and pwm_out holds its last value. Resuming continues from the held state.

Test Plan:
- Edge, prescale=0, P=9, duty0=3, duty1=0, duty2=10, pol=0:
  - pwm_out[0] is high for 3 of every 10 cycles.
  - ch1 stays 0 and ch2 stays 1.
  - period_tick pulses every 10 cycles.
- Center, prescale=0, P=4, duty0=2: cnt runs 0,1,2,3,4,3,2,1; pwm_out[0] is high for 3 of every 8 cycles (symmetric about cnt=0); period_tick every 8 cycles.
- Prescaler: prescale=2, edge, P=3, duty0=2 -> 12-cycle period with 6 cycles high; each cnt value is held for 3 clk cycles.
- Shadow update: running P=9, duty0=3; pulse load with duty0=7 at cnt=4:
  - the output keeps 3/10 until the boundary.
  - load_ack and period_tick pulse together.
  - the next period is 7/10.
  - a load on the commit edge defers to the following boundary.
- Polarity and enable: set polarity0=1 via load -> ch0 shows the complement. Drop enable for 5 cycles -> cnt and pwm_out frozen with no period_tick; resume continues seamlessly.
- Reset mid-period with pending load: all outputs 0 the next cycle, no load_ack ever appears, and after reset P=0/duty=0 gives constant-0 outputs.
